// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus engines: bus timing defaults,
// the read-engine state encoding and the microsecond-to-cycle conversion.
package lcd_pkg;

  localparam int unsigned LCD_TIMER_W    = 21;
  localparam int unsigned LCD_FREQ_HZ    = 50_000_000;
  localparam int unsigned LCD_SETUP_US   = 1;
  localparam int unsigned LCD_E_HIGH_US  = 3;
  localparam int unsigned LCD_SAMPLE_US  = 2;
  localparam int unsigned LCD_HOLD_US    = 1;
  localparam int unsigned LCD_GAP_US     = 2;
  localparam int unsigned LCD_POLL_LIMIT = 1000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    GAP,
    DONE
  } rd_state_e;

  // 64-bit intermediate keeps us*freq from overflowing at high clock rates.
  function automatic int unsigned us2cyc(input int unsigned us, input int unsigned freq);
    return int'((64'(us) * 64'(freq)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Free-running 21-bit cycle counter used by the LCD engines to time bus phases;
// i_clear restarts it from zero on the following cycle.
module lcd_delay_timer
  import lcd_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_clear,
  output logic [LCD_TIMER_W-1:0] o_count
);

  logic [LCD_TIMER_W-1:0] r_count;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || i_clear) r_count <= '0;
    else                r_count <= r_count + LCD_TIMER_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/lcd_read_transfer.sv
// One HD44780 bus read (RW=1): setup, E pulse with mid-pulse data sample, hold.
// Optionally re-reads the busy flag until it clears or the poll limit is hit.
module lcd_read_transfer
  import lcd_pkg::*;
#(
  parameter int unsigned FREQ       = LCD_FREQ_HZ,
  parameter int unsigned SETUP_US   = LCD_SETUP_US,
  parameter int unsigned E_HIGH_US  = LCD_E_HIGH_US,
  parameter int unsigned SAMPLE_US  = LCD_SAMPLE_US,
  parameter int unsigned HOLD_US    = LCD_HOLD_US,
  parameter int unsigned GAP_US     = LCD_GAP_US,
  parameter int unsigned POLL_LIMIT = LCD_POLL_LIMIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       readReq,
  input  logic       readRS,
  input  logic       pollBusy,
  input  logic [7:0] LCD_D_IN,
  output logic       LCD_D_OE,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] readData,
  output logic       busyFlag,
  output logic [6:0] addrCounter,
  output logic       readDone,
  output logic       timeoutErr
);

  localparam logic [LCD_TIMER_W-1:0] SETUP_LAST  = LCD_TIMER_W'(us2cyc(SETUP_US, FREQ) - 1);
  localparam logic [LCD_TIMER_W-1:0] E_HIGH_LAST = LCD_TIMER_W'(us2cyc(E_HIGH_US, FREQ) - 1);
  localparam logic [LCD_TIMER_W-1:0] SAMPLE_LAST = LCD_TIMER_W'(us2cyc(SAMPLE_US, FREQ) - 1);
  localparam logic [LCD_TIMER_W-1:0] HOLD_LAST   = LCD_TIMER_W'(us2cyc(HOLD_US, FREQ) - 1);
  localparam logic [LCD_TIMER_W-1:0] GAP_LAST    = LCD_TIMER_W'(us2cyc(GAP_US, FREQ) - 1);
  localparam int unsigned            CNT_W       = $clog2(POLL_LIMIT + 1);

  rd_state_e              r_state;
  rd_state_e              w_next_state;
  logic                   r_rs;
  logic                   r_poll;
  logic [CNT_W-1:0]       r_poll_cnt;
  logic [7:0]             r_data;
  logic                   r_timeout;

  logic [LCD_TIMER_W-1:0] w_timer;
  logic                   w_timer_clear;
  logic                   w_accept;
  logic                   w_sample;
  logic                   w_hold_end;
  logic [CNT_W-1:0]       w_poll_cnt_inc;
  logic                   w_limit_hit;
  logic                   w_still_busy;

  lcd_delay_timer u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .i_clear (w_timer_clear),
    .o_count (w_timer)
  );

  assign w_poll_cnt_inc = r_poll_cnt + CNT_W'(1);
  assign w_limit_hit    = (w_poll_cnt_inc >= CNT_W'(POLL_LIMIT));
  assign w_still_busy   = r_poll && r_data[7];
  assign w_accept       = (r_state == IDLE) && readReq;
  // Every state change restarts the phase timer at zero.
  assign w_timer_clear  = (w_next_state != r_state);

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    w_hold_end   = 1'b0;
    case (r_state)
      IDLE:   if (readReq) w_next_state = SETUP;
      SETUP:  if (w_timer == SETUP_LAST) w_next_state = E_HIGH;
      E_HIGH: begin
        w_sample = (w_timer == SAMPLE_LAST);
        if (w_timer == E_HIGH_LAST) w_next_state = HOLD;
      end
      HOLD: begin
        if (w_timer == HOLD_LAST) begin
          w_hold_end   = 1'b1;
          w_next_state = (w_still_busy && !w_limit_hit) ? GAP : DONE;
        end
      end
      GAP:    if (w_timer == GAP_LAST) w_next_state = SETUP;
      DONE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rs       <= 1'b0;
      r_poll     <= 1'b0;
      r_poll_cnt <= '0;
      r_data     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_rs       <= pollBusy ? 1'b0 : readRS;
        r_poll     <= pollBusy;
        r_poll_cnt <= '0;
        r_timeout  <= 1'b0;
      end
      if (w_sample) r_data <= LCD_D_IN;
      if (w_hold_end) begin
        r_poll_cnt <= w_poll_cnt_inc;
        if (w_still_busy && w_limit_hit) r_timeout <= 1'b1;
      end
    end
  end

  // Bus pins decode straight from state so E can never glitch outside E_HIGH.
  assign LCD_D_OE    = 1'b0;
  assign LCD_RW      = (r_state == SETUP) || (r_state == E_HIGH) || (r_state == HOLD);
  assign LCD_RS      = LCD_RW && r_rs;
  assign LCD_E       = (r_state == E_HIGH);
  assign readDone    = (r_state == DONE);
  assign readData    = r_data;
  assign busyFlag    = r_data[7];
  assign addrCounter = r_data[6:0];
  assign timeoutErr  = r_timeout;

endmodule

// File: tb/tb_lcd_read_transfer.sv
// Directed plus randomized bench for lcd_read_transfer; expectations come from a
// transfer-level model (read count, pulse timing, sampled byte) built from bus rules.
module tb_lcd_read_transfer;

  localparam int SETUP_CYC  = 50;
  localparam int E_HIGH_CYC = 150;
  localparam int SAMPLE_CYC = 100;
  localparam int HOLD_CYC   = 50;
  localparam int GAP_CYC    = 100;
  localparam int LIMIT      = 3;
  localparam int READ_CYC   = SETUP_CYC + E_HIGH_CYC + HOLD_CYC;
  localparam int POLL_CYC   = GAP_CYC + READ_CYC;
  localparam int TAIL       = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       readReq = 1'b0;
  logic       readRS = 1'b0;
  logic       pollBusy = 1'b0;
  logic [7:0] LCD_D_IN = 8'h00;
  logic       LCD_D_OE, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] readData;
  logic       busyFlag;
  logic [6:0] addrCounter;
  logic       readDone, timeoutErr;

  int n_checks = 0;
  int n_errors = 0;

  lcd_read_transfer #(.POLL_LIMIT(LIMIT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .readReq     (readReq),
    .readRS      (readRS),
    .pollBusy    (pollBusy),
    .LCD_D_IN    (LCD_D_IN),
    .LCD_D_OE    (LCD_D_OE),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_E       (LCD_E),
    .readData    (readData),
    .busyFlag    (busyFlag),
    .addrCounter (addrCounter),
    .readDone    (readDone),
    .timeoutErr  (timeoutErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches the bus. cyc counts edges after the accepting
  // edge, so cyc N is the spec's cycle k+1+N; readDone is due at cyc READ_CYC.
  task automatic run_transfer(input string tag, input logic rs, input logic poll,
                              input logic [7:0] busy_val, input int n_busy,
                              input logic [7:0] clear_val, input int chg_at,
                              input logic [7:0] chg_val, input int rereq_at);
    int exp_reads, exp_done, rises, hi_len, done_cnt, done_at, rw_cnt, first_rise, last_rise;
    logic exp_tmo, exp_rs, prev_e, got_tmo;
    logic [7:0] exp_data, got_data;
    bit len_bad, rs_bad, oe_bad, e_bad;

    exp_reads = poll ? ((n_busy + 1 < LIMIT) ? n_busy + 1 : LIMIT) : 1;
    exp_tmo   = poll && (n_busy >= LIMIT);
    exp_rs    = poll ? 1'b0 : rs;
    exp_data  = (poll && exp_reads <= n_busy) ? busy_val : clear_val;
    if (chg_at >= 0 && chg_at < SETUP_CYC + SAMPLE_CYC) exp_data = chg_val;
    exp_done  = READ_CYC + (exp_reads - 1) * POLL_CYC;

    rises = 0; hi_len = 0; done_cnt = 0; done_at = -1; rw_cnt = 0;
    first_rise = -1; last_rise = -1; prev_e = 1'b0; got_tmo = 1'b0; got_data = 8'h00;
    len_bad = 0; rs_bad = 0; oe_bad = 0; e_bad = 0;

    LCD_D_IN = ~clear_val;
    readRS   = rs;
    pollBusy = poll;
    readReq  = 1'b1;
    @(posedge CLK); #1;
    readReq = 1'b0;
    check({tag, "/tmo_cleared_on_accept"}, timeoutErr, 0);

    for (int cyc = 0; cyc < exp_done + 400; cyc++) begin
      if (cyc > 0) begin
        @(posedge CLK); #1;
      end
      readReq = (cyc == rereq_at);
      if (LCD_E && !prev_e) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        last_rise = cyc;
        LCD_D_IN = (poll && rises <= n_busy) ? busy_val : clear_val;
      end
      if (cyc == chg_at) LCD_D_IN = chg_val;
      if (LCD_E) hi_len++;
      else if (prev_e) begin
        if (hi_len != E_HIGH_CYC) len_bad = 1;
        hi_len = 0;
      end
      if (LCD_E && !LCD_RW) e_bad = 1;
      if (LCD_RW) begin
        rw_cnt++;
        if (LCD_RS !== exp_rs) rs_bad = 1;
      end
      if (LCD_D_OE !== 1'b0) oe_bad = 1;
      if (readDone === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at  = cyc;
          got_data = readData;
          got_tmo  = timeoutErr;
        end
      end
      prev_e = LCD_E;
      if (done_at >= 0 && cyc == done_at + TAIL) break;
    end
    readReq = 1'b0;

    check({tag, "/done_count"},   done_cnt, 1);
    check({tag, "/done_cycle"},   done_at, exp_done);
    check({tag, "/e_pulses"},     rises, exp_reads);
    check({tag, "/first_rise"},   first_rise, SETUP_CYC);
    check({tag, "/last_rise"},    last_rise, SETUP_CYC + (exp_reads - 1) * POLL_CYC);
    check({tag, "/e_width_bad"},  len_bad, 0);
    check({tag, "/e_without_rw"}, e_bad, 0);
    check({tag, "/rs_bad"},       rs_bad, 0);
    check({tag, "/oe_bad"},       oe_bad, 0);
    check({tag, "/rw_cycles"},    rw_cnt, exp_reads * READ_CYC);
    check({tag, "/data_at_done"}, got_data, exp_data);
    check({tag, "/busy_flag"},    busyFlag, exp_data[7]);
    check({tag, "/addr_counter"}, addrCounter, exp_data[6:0]);
    check({tag, "/tmo_at_done"},  got_tmo, exp_tmo);
    check({tag, "/tmo_sticky"},   timeoutErr, exp_tmo);
  endtask

  initial begin
    logic seen;
    logic p;
    int   nb;

    repeat (3) @(posedge CLK);
    #1;
    check("reset/e",    LCD_E, 0);
    check("reset/rw",   LCD_RW, 0);
    check("reset/rs",   LCD_RS, 0);
    check("reset/oe",   LCD_D_OE, 0);
    check("reset/data", readData, 8'h00);
    check("reset/done", readDone, 0);
    check("reset/tmo",  timeoutErr, 0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    run_transfer("single_data", 1'b1, 1'b0, 8'h00, 0, 8'h5A, -1, 8'h00, -1);
    run_transfer("poll_clears", 1'b1, 1'b1, 8'h85, 2, 8'h12, -1, 8'h00, -1);
    run_transfer("poll_timeout", 1'b0, 1'b1, 8'h80, 10, 8'h80, -1, 8'h00, -1);
    run_transfer("after_timeout", 1'b0, 1'b0, 8'h00, 0, 8'h3C, -1, 8'h00, -1);
    run_transfer("sample_early", 1'b1, 1'b0, 8'h00, 0, 8'h11,
                 SETUP_CYC + SAMPLE_CYC - 1, 8'h22, -1);
    run_transfer("sample_late", 1'b1, 1'b0, 8'h00, 0, 8'h11,
                 SETUP_CYC + SAMPLE_CYC, 8'h22, -1);
    run_transfer("ignored_req", 1'b1, 1'b0, 8'h00, 0, 8'hA7, -1, 8'h00, SETUP_CYC + 70);

    // Reset during E high: the bus must drop at once and never complete.
    readRS = 1'b1; pollBusy = 1'b0; LCD_D_IN = 8'h99;
    readReq = 1'b1;
    @(posedge CLK); #1;
    readReq = 1'b0;
    repeat (SETUP_CYC + 50) @(posedge CLK);
    #1;
    check("rst_mid/e_before", LCD_E, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_mid/e",    LCD_E, 0);
    check("rst_mid/rw",   LCD_RW, 0);
    check("rst_mid/done", readDone, 0);
    check("rst_mid/data", readData, 8'h00);
    seen = 1'b0;
    repeat (READ_CYC + 50) begin
      @(posedge CLK); #1;
      if (readDone || LCD_RW || LCD_E) seen = 1'b1;
    end
    check("rst_mid/no_activity", seen, 0);

    // Request coinciding with reset must be dropped.
    RST = 1'b1; readReq = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; readReq = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (LCD_RW) seen = 1'b1;
    end
    check("rst_and_req/no_transfer", seen, 0);

    run_transfer("after_reset", 1'b1, 1'b0, 8'h00, 0, 8'h6E, -1, 8'h00, -1);

    for (int i = 0; i < 6; i++) begin
      p = 1'($urandom_range(0, 1));
      if (p) begin
        nb = int'($urandom_range(0, 4));
        run_transfer($sformatf("rand%0d_poll", i), 1'($urandom), 1'b1,
                     8'h80 | 8'($urandom_range(0, 127)), nb,
                     8'($urandom_range(0, 127)), -1, 8'h00, -1);
      end else begin
        run_transfer($sformatf("rand%0d_read", i), 1'($urandom), 1'b0, 8'h00, 0,
                     8'($urandom), -1, 8'h00, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_read_transfer.md
Name: lcd_read_transfer

Overview:
- Read-direction counterpart of the LCD write transfer engine, for the same HD44780-style parallel LCD bus.
- Performs one bus read cycle with RW=1: address setup, E pulse, data sample while E is high, then hold.
- Returns the sampled byte. Optionally re-polls the busy flag until it clears or a poll limit is reached.
- Sits beside the write engine under the LCD controller FSM. The controller owns bus arbitration and the tristate pad, and drives the pad from LCD_D_OE.

Parameters:
- FREQ, 50000000: clock frequency in Hz.
- SETUP_US, 1: RS/RW setup time before E rises, in µs.
- E_HIGH_US, 3: E high width, in µs.
- SAMPLE_US, 2: delay from E rise to data sample, in µs. Must be less than E_HIGH_US.
- HOLD_US, 1: hold time after E falls, in µs.
- GAP_US, 2: idle gap between busy polls, in µs.
- POLL_LIMIT, 1000: maximum number of bus reads in one poll request.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: synchronous, active-high reset.
- readReq, input, 1: start-request pulse. Honoured only in IDLE.
- readRS, input, 1: register select. 0 = busy flag/address, 1 = data RAM. Ignored when pollBusy=1.
- pollBusy, input, 1: repeat reads until busy flag clears.
- LCD_D_IN, input, 8: data from pad.
- LCD_D_OE, output, 1: pad output enable. Always 0 from this block; exported so the controller can OR the enables of both engines.
- LCD_RS, output, 1: register select to LCD.
- LCD_RW, output, 1: 1 during a transfer.
- LCD_E, output, 1: enable strobe.
- readData, output, 8: last sampled byte.
- busyFlag, output, 1: equals readData[7].
- addrCounter, output, 7: equals readData[6:0].
- readDone, output, 1: one-cycle completion pulse.
- timeoutErr, output, 1: poll limit reached while still busy. Sticky until the next accepted request.

Behaviour:
- Cycle counts: X_CYC = X_US * FREQ/1000000. Defaults give SETUP 50, E_HIGH 150, SAMPLE 100, HOLD 50, GAP 100 cycles.
- Timer: 21-bit, cleared on every state entry.
- Reset values: all outputs 0, state IDLE, poll counter 0. Reset mid-transfer drops E low in the next cycle and aborts with no readDone.
- IDLE:
  - Outputs E=0, RW=0, RS=0.
  - On readReq, latch rsReg (= pollBusy ? 0 : readRS) and pollReg, clear the poll counter and timeoutErr, then go to SETUP.
- SETUP:
  - RW=1, RS=rsReg, E=0.
  - When timer==SETUP_CYC-1, go to E_HIGH.
- E_HIGH:
  - RW=1, RS=rsReg, E=1.
  - When timer==SAMPLE_CYC-1, register LCD_D_IN into readData.
  - When timer==E_HIGH_CYC-1, go to HOLD.
- HOLD:
  - RW=1, RS=rsReg, E=0.
  - When timer==HOLD_CYC-1, increment the poll counter, then:
    - if pollReg and readData[7]=1 and count < POLL_LIMIT, go to GAP;
    - if pollReg and readData[7]=1 and count == POLL_LIMIT, set timeoutErr and go to DONE;
    - otherwise go to DONE.
- GAP:
  - RW=0, E=0.
  - When timer==GAP_CYC-1, go to SETUP.
- DONE:
  - readDone=1 for exactly one cycle, then IDLE.
  - readData is stable from the sample until the next sample.
- Latency: readReq accepted at edge k gives a single read with readDone high in cycle k+1+SETUP+E_HIGH+HOLD, which is k+251 at defaults.
- Each extra poll adds GAP+SETUP+E_HIGH+HOLD = 350 cycles.
- readReq outside IDLE is ignored with no queueing.
- readReq and RST in the same cycle: RST wins.
- LCD_E is never high outside E_HIGH.
- RS and RW are stable for the whole SETUP..HOLD window.

Decomposition:
- Package lcd_pkg holds:
  - typedef enum for the read states: IDLE, SETUP, E_HIGH, HOLD, GAP, DONE;
  - a constant function us2cyc(us, freq);
  - the shared timing constants, also used by the write engine.
- Sub-module lcd_delay_timer: 21-bit up-counter with clear input and count output, shared by the read and write engines.

Test Plan:
- Single data read: readRS=1, pollBusy=0, LCD_D_IN=0x5A.
  - Required: E high for exactly 150 cycles; RS=1 and RW=1 throughout the transfer.
  - Required: readData=0x5A; readDone high in cycle k+251 only.
- Busy poll clears: pollBusy=1, LCD_D_IN=0x85 for the first two reads, then 0x12.
  - Required: three E pulses 350 cycles apart; RS=0.
  - Required: busyFlag=0, addrCounter=0x12, timeoutErr=0.
- Poll timeout: POLL_LIMIT=3, LCD_D_IN stuck at 0x80.
  - Required: exactly 3 E pulses, then timeoutErr=1 with readDone.
  - Required: timeoutErr clears on the next accepted readReq.
- Sample point: LCD_D_IN changes from 0x11 to 0x22 at E-rise+99 cycles.
  - Required: readData=0x22. Changing it instead at E-rise+100 gives readData=0x11.
- Ignored request: pulse readReq again during E_HIGH.
  - Required: no second transfer; exactly one readDone.
- Reset mid-transfer: RST asserted during E_HIGH.
  - Required: next cycle E=0, RW=0, state IDLE, no readDone.
  - Required: a new readReq completes normally afterwards.
